hamming_decoder: RTL and testbench
==================================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 CNT_W, 16, width of each saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 code_in  input  13  codeword; bit0=p1, bit1=p2, bit2=D0, bit3=p4, bit4=D1, bit5=D2, bit6=D3, bit7=p8, bit8=D4, bit9=D5, bit10=D6, bit11=D7, bit12=p0 (overall parity).
REQ-005 in_valid  input  1  code_in valid.
REQ-006 in_ready  output  1  decoder accepts code_in this cycle.
REQ-007 data_out  output  8  corrected data {D7..D0}.
REQ-008 err_single  output  1  single-bit error detected and corrected.
REQ-009 err_double  output  1  uncorrectable error detected.
REQ-010 err_pos  output  4  code_in bit index corrected (0-12) when err_single, else 0.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 cnt_single  output  CNT_W  count of accepted err_single results.
REQ-015 cnt_double  output  CNT_W  count of accepted err_double results.

Function
REQ-016 Transfer occurs on any edge where valid and ready are both high; inputs are sampled only then.
REQ-017 Two-stage pipeline: S1 registers code_in plus 4-bit syndrome and overall-parity check; S2 registers corrected data and flags.
REQ-018 Syndrome = XOR of positions (index+1) of all set bits among code_in[11:0]; parity_fail = XOR of code_in[12:0].
REQ-019 syndrome=0, no parity_fail -> no error; data passed unchanged.
REQ-020 syndrome 1-12 with parity_fail -> invert bit (syndrome-1), err_single=1, err_pos=syndrome-1.
REQ-021 syndrome=0 with parity_fail -> p0 error; data unchanged, err_single=1, err_pos=12.
REQ-022 syndrome nonzero, no parity_fail -> err_double=1, data_out = uncorrected data bits.
REQ-023 syndrome 13-15 with parity_fail -> err_double=1, data_out = uncorrected data bits.
REQ-024 err_single and err_double are never both 1.
REQ-025 Latency: result on out_valid 2 cycles after input transfer when not stalled; throughput 1 word/cycle.
REQ-026 S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when in_valid and in_ready.
REQ-027 in_ready = !S1_valid || S2 loads this cycle (combinational from out_ready allowed).
REQ-028 While out_valid && !out_ready, data_out, flags, err_pos hold stable; no word dropped or duplicated.
REQ-029 Counters increment once per output transfer with the corresponding flag; saturate at 2^CNT_W-1.
REQ-030 cnt_clr has priority over a same-cycle increment; counters read 0 next cycle.

Reset
REQ-031 rst_n low asynchronously clears both stage valids, data_out, err_single, err_double, err_pos, cnt_single, cnt_double to 0; in_ready reads 1 while pipeline empty.
REQ-032 Reset mid-operation discards in-flight words; no output transfer follows without new input.

Verification
REQ-033 code_in=0x1061 (data 0x0C), out_ready=1 -> 2 cycles later data_out=0x0C, no flags, counters unchanged.
REQ-034 code_in=0x1041 (bit5 flipped) -> data_out=0x0C, err_single=1, err_pos=5, cnt_single+1; code_in=0x0061 -> data_out=0x0C, err_single=1, err_pos=12.
REQ-035 code_in=0x1062 (bits0,1 flipped) -> err_double=1, err_single=0, cnt_double+1; code_in=0x1862 (syndrome 15, parity fail) -> err_double=1.
REQ-036 Back-to-back 4 words with out_ready low for 3 cycles -> in_ready drops after 2 accepted, outputs held, all 4 emerge in order.
REQ-037 Drive cnt_single to 0xFFFF, send a single-error word -> stays 0xFFFF; assert cnt_clr with simultaneous flagged transfer -> both 0.

Source files
------------

// File: rtl/hamming_decoder.sv
// Two-stage pipelined SECDED decoder for a 13-bit extended Hamming(12,8) codeword.
// Stage 1 captures the word with its syndrome; stage 2 holds the corrected byte, flags and counters.
module hamming_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [12:0]      code_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       data_out,
   output logic             err_single,
   output logic             err_double,
   output logic [3:0]       err_pos,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_single,
   output logic [CNT_W-1:0] cnt_double
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Bit gi of the syndrome covers every position (index+1) whose bit gi is set.
   function automatic logic [11:0] syn_mask(input int bit_idx);
      logic [11:0] m;
      m = '0;
      for (int p = 1; p <= 12; p++) begin
         m[p-1] = ((p >> bit_idx) & 1) != 0;
      end
      return m;
   endfunction

   logic [3:0]       syn_next;
   logic             pfail_next;

   logic             s1_valid_reg;
   logic [12:0]      s1_code_reg;
   logic [3:0]       s1_syn_reg;
   logic             s1_pfail_reg;

   logic             s2_valid_reg;
   logic [7:0]       data_reg;
   logic             single_reg;
   logic             double_reg;
   logic [3:0]       pos_reg;
   logic [CNT_W-1:0] cnt_single_reg;
   logic [CNT_W-1:0] cnt_double_reg;

   logic             s1_load;
   logic             s2_load;
   logic             out_xfer;

   logic             fix_data;
   logic             fix_p0;
   logic             dbl_next;
   logic [12:0]      corrected;
   logic [7:0]       data_next;
   logic [3:0]       pos_next;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_syn
         assign syn_next[gi] = ^(code_in[11:0] & syn_mask(gi));
      end
   endgenerate

   assign pfail_next = ^code_in;

   assign s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);
   assign in_ready = !s1_valid_reg || s2_load;
   assign s1_load  = in_valid && in_ready;
   assign out_xfer = s2_valid_reg && out_ready;

   always_comb begin
      fix_data  = s1_pfail_reg && (s1_syn_reg != 4'd0) && (s1_syn_reg <= 4'd12);
      fix_p0    = s1_pfail_reg && (s1_syn_reg == 4'd0);
      // Any nonzero syndrome that is not a correctable single flip is uncorrectable.
      dbl_next  = (s1_syn_reg != 4'd0) && !fix_data;
      corrected = s1_code_reg ^ (fix_data ? (13'd1 << (s1_syn_reg - 4'd1)) : 13'd0);
      data_next = {corrected[11], corrected[10], corrected[9], corrected[8],
                   corrected[6], corrected[5], corrected[4], corrected[2]};
      pos_next  = 4'd0;
      if (fix_data) begin
         pos_next = s1_syn_reg - 4'd1;
      end else if (fix_p0) begin
         pos_next = 4'd12;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_code_reg  <= '0;
         s1_syn_reg   <= '0;
         s1_pfail_reg <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= 1'b1;
         s1_code_reg  <= code_in;
         s1_syn_reg   <= syn_next;
         s1_pfail_reg <= pfail_next;
      end else if (s2_load) begin
         s1_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         data_reg     <= '0;
         single_reg   <= 1'b0;
         double_reg   <= 1'b0;
         pos_reg      <= '0;
      end else if (s2_load) begin
         s2_valid_reg <= 1'b1;
         data_reg     <= data_next;
         single_reg   <= fix_data || fix_p0;
         double_reg   <= dbl_next;
         pos_reg      <= pos_next;
      end else if (out_xfer) begin
         s2_valid_reg <= 1'b0;
      end
   end

   // Counters advance only on an accepted result; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_single_reg <= '0;
         cnt_double_reg <= '0;
      end else if (cnt_clr) begin
         cnt_single_reg <= '0;
         cnt_double_reg <= '0;
      end else if (out_xfer) begin
         if (single_reg && (cnt_single_reg != CNT_MAX)) begin
            cnt_single_reg <= cnt_single_reg + 1'b1;
         end
         if (double_reg && (cnt_double_reg != CNT_MAX)) begin
            cnt_double_reg <= cnt_double_reg + 1'b1;
         end
      end
   end

   assign out_valid  = s2_valid_reg;
   assign data_out   = data_reg;
   assign err_single = single_reg;
   assign err_double = double_reg;
   assign err_pos    = pos_reg;
   assign cnt_single = cnt_single_reg;
   assign cnt_double = cnt_double_reg;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: expected results are queued at input
// acceptance and popped by a monitor on every output transfer.
module tb_hamming_decoder;

   typedef struct packed {
      logic [7:0] data;
      logic       single;
      logic       dbl;
      logic [3:0] pos;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [12:0] code_in;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  data_out;
   logic        err_single;
   logic        err_double;
   logic [3:0]  err_pos;
   logic        out_valid;
   logic        out_ready;
   logic        cnt_clr;
   logic [15:0] cnt_single;
   logic [15:0] cnt_double;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_acc = 0;
   exp_t        sb_q[$];
   logic [15:0] exp_single = '0;
   logic [15:0] exp_double = '0;

   hamming_decoder #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .err_single (err_single),
      .err_double (err_double),
      .err_pos    (err_pos),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cnt_clr    (cnt_clr),
      .cnt_single (cnt_single),
      .cnt_double (cnt_double)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode: locate the flipped bit by summing positions, then classify.
   function automatic exp_t model(input logic [12:0] c);
      exp_t        e;
      logic [3:0]  syn;
      logic        pf;
      logic [12:0] cc;
      syn = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (c[i]) syn = syn ^ 4'(i + 1);
      end
      pf = ^c;
      cc = c;
      e  = '0;
      if (syn == 4'd0 && pf) begin
         e.single = 1'b1;
         e.pos    = 4'd12;
      end else if (syn != 4'd0 && pf && syn <= 4'd12) begin
         cc[syn - 4'd1] = ~cc[syn - 4'd1];
         e.single = 1'b1;
         e.pos    = syn - 4'd1;
      end else if (syn != 4'd0) begin
         e.dbl = 1'b1;
      end
      e.data = {cc[11], cc[10], cc[9], cc[8], cc[6], cc[5], cc[4], cc[2]};
      return e;
   endfunction

   function automatic logic [12:0] encode(input logic [7:0] d);
      logic [12:0] c;
      logic [3:0]  syn;
      c = '0;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      c[8] = d[4]; c[9] = d[5]; c[10] = d[6]; c[11] = d[7];
      syn = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (c[i]) syn = syn ^ 4'(i + 1);
      end
      c[0] = syn[0]; c[1] = syn[1]; c[3] = syn[2]; c[7] = syn[3];
      c[12] = ^c[11:0];
      return c;
   endfunction

   // Monitor: checks each output transfer and tracks the counter model for the coming edge.
   initial begin
      exp_t got;
      exp_t want;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_single = '0;
            exp_double = '0;
         end else begin
            if (out_valid && out_ready) begin
               got = {data_out, err_single, err_double, err_pos};
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_output: got %h with no word pending", got);
               end else begin
                  want = sb_q.pop_front();
                  if (got !== want) begin
                     n_err++;
                     $display("FAIL output_word: got data=%h s=%b d=%b pos=%0d, want data=%h s=%b d=%b pos=%0d",
                              got.data, got.single, got.dbl, got.pos,
                              want.data, want.single, want.dbl, want.pos);
                  end
               end
            end
            if (cnt_clr) begin
               exp_single = '0;
               exp_double = '0;
            end else if (out_valid && out_ready) begin
               if (err_single && exp_single != 16'hFFFF) exp_single = exp_single + 16'd1;
               if (err_double && exp_double != 16'hFFFF) exp_double = exp_double + 16'd1;
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepts the word.
   task automatic send_word(input logic [12:0] c);
      bit ok;
      ok       = 1'b0;
      code_in  = c;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(model(c));
            n_acc++;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: word %h not accepted, want acceptance within 50 cycles", c);
      end
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (sb_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d words pending, want 0", sb_q.size());
      end
   endtask

   task automatic check_counters(input string tag);
      n_cmp++;
      if (cnt_single !== exp_single || cnt_double !== exp_double) begin
         n_err++;
         $display("FAIL %s_counters: got single=%h double=%h, want single=%h double=%h",
                  tag, cnt_single, cnt_double, exp_single, exp_double);
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, data_out, err_single, err_double, err_pos, cnt_single, cnt_double} !== '0
          || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: got ov=%b data=%h s=%b d=%b pos=%0d cs=%h cd=%h ir=%b, want all 0 and ir=1",
                  out_valid, data_out, err_single, err_double, err_pos, cnt_single, cnt_double, in_ready);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
      end
   endtask

   task automatic test_clean();
      send_word(13'h1061);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL latency_early: got out_valid=%b one cycle after accept, want 0", out_valid);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || data_out !== 8'h0C || err_single !== 1'b0 || err_double !== 1'b0) begin
         n_err++;
         $display("FAIL latency_clean: got ov=%b data=%h s=%b d=%b, want ov=1 data=0c s=0 d=0",
                  out_valid, data_out, err_single, err_double);
      end
      wait_drain();
      n_cmp++;
      if (cnt_single !== 16'd0 || cnt_double !== 16'd0) begin
         n_err++;
         $display("FAIL clean_counters: got single=%h double=%h, want 0 0", cnt_single, cnt_double);
      end
   endtask

   task automatic test_single();
      send_word(13'h1041);
      send_word(13'h0061);
      wait_drain();
      n_cmp++;
      if (cnt_single !== 16'd2) begin
         n_err++;
         $display("FAIL single_count: got %h, want 0002", cnt_single);
      end
   endtask

   task automatic test_double();
      send_word(13'h1062);
      send_word(13'h1862);
      wait_drain();
      n_cmp++;
      if (cnt_double !== 16'd2 || cnt_single !== 16'd2) begin
         n_err++;
         $display("FAIL double_count: got double=%h single=%h, want 0002 0002", cnt_double, cnt_single);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] w[4];
      exp_t        head;
      exp_t        got;
      int          base;
      w[0] = 13'h1061;
      w[1] = 13'h1041;
      w[2] = 13'h1062;
      w[3] = encode(8'hA5);
      head = model(w[0]);
      base = n_acc;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send_word(w[i]);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #2;
            n_cmp++;
            if (n_acc - base !== 2) begin
               n_err++;
               $display("FAIL stall_accept_count: got %0d accepted, want 2", n_acc - base);
            end
            for (int c = 0; c < 3; c++) begin
               got = {data_out, err_single, err_double, err_pos};
               n_cmp++;
               if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== head) begin
                  n_err++;
                  $display("FAIL stall_hold cycle %0d: got ov=%b ir=%b out=%h, want ov=1 ir=0 out=%h",
                           c, out_valid, in_ready, got, head);
               end
               @(posedge clk);
               #2;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check_counters("back_to_back");
   endtask

   task automatic test_random();
      bit          done;
      logic [12:0] c;
      int          nflip;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               c = encode(8'($urandom));
               nflip = $urandom_range(0, 2);
               for (int f = 0; f < nflip; f++) c[$urandom_range(0, 12)] ^= 1'b1;
               send_word(c);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #2;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
      check_counters("random");
   endtask

   task automatic test_saturate();
      int need;
      need = 16'hFFFF - exp_single;
      for (int i = 0; i < need; i++) send_word(13'h1041);
      wait_drain();
      n_cmp++;
      if (cnt_single !== 16'hFFFF) begin
         n_err++;
         $display("FAIL saturate_reach: got %h, want ffff", cnt_single);
      end
      send_word(13'h0061);
      wait_drain();
      n_cmp++;
      if (cnt_single !== 16'hFFFF) begin
         n_err++;
         $display("FAIL saturate_hold: got %h, want ffff", cnt_single);
      end
   endtask

   task automatic test_clear();
      send_word(13'h1041);
      @(posedge clk);
      #1;
      cnt_clr = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b1 || err_single !== 1'b1) begin
         n_err++;
         $display("FAIL clear_setup: got ov=%b s=%b, want flagged result present with clear", out_valid, err_single);
      end
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      n_cmp++;
      if (cnt_single !== 16'd0 || cnt_double !== 16'd0) begin
         n_err++;
         $display("FAIL clear_priority: got single=%h double=%h, want 0 0", cnt_single, cnt_double);
      end
      wait_drain();
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      send_word(13'h1062);
      send_word(13'h1041);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      n_cmp++;
      if ({out_valid, data_out, err_single, err_double, err_pos, cnt_single, cnt_double} !== '0
          || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: got ov=%b data=%h s=%b d=%b pos=%0d cs=%h cd=%h ir=%b, want all 0 and ir=1",
                  out_valid, data_out, err_single, err_double, err_pos, cnt_single, cnt_double, in_ready);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_discard: got ov=%b, want 0 with no new input", out_valid);
      end
      // Pipeline must still work after the flush.
      send_word(13'h1062);
      wait_drain();
      check_counters("post_reset");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      code_in   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_back_to_back();
      test_random();
      test_saturate();
      test_clear();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
